// File: rtl/hazard_sequencer_if.sv
// Signal bundle between the decode/execute datapath, the hazard sequencer and the stage controller.
// The master side drives instruction info and reads hazards; the slave side is the sequencer.
interface hazard_sequencer_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      decodeValid;
  logic                      decodeIsBranch;
  logic [REG_ADDR_WIDTH-1:0] decodeRs1;
  logic [REG_ADDR_WIDTH-1:0] decodeRs2;
  logic                      decodeRs1Used;
  logic                      decodeRs2Used;
  logic                      executeValid;
  logic                      executeIsLoad;
  logic [REG_ADDR_WIDTH-1:0] executeRd;
  logic                      branchResolved;
  logic                      branchMispredict;
  logic                      statClear;
  logic                      isDataHazard;
  logic                      isBranchHazard;
  logic                      isBranchHazardDelayed;
  logic                      isMiss;
  logic                      errorTimeout;
  logic [CNT_WIDTH-1:0]      dataHazardCycles;
  logic [CNT_WIDTH-1:0]      branchHazardCycles;
  logic [CNT_WIDTH-1:0]      missCount;

  modport master (
    output decodeValid, decodeIsBranch, decodeRs1, decodeRs2, decodeRs1Used, decodeRs2Used,
    output executeValid, executeIsLoad, executeRd, branchResolved, branchMispredict, statClear,
    input  isDataHazard, isBranchHazard, isBranchHazardDelayed, isMiss, errorTimeout,
    input  dataHazardCycles, branchHazardCycles, missCount
  );

  modport slave (
    input  decodeValid, decodeIsBranch, decodeRs1, decodeRs2, decodeRs1Used, decodeRs2Used,
    input  executeValid, executeIsLoad, executeRd, branchResolved, branchMispredict, statClear,
    output isDataHazard, isBranchHazard, isBranchHazardDelayed, isMiss, errorTimeout,
    output dataHazardCycles, branchHazardCycles, missCount
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use detection, branch resolution wait FSM with timeout, delayed fetch stall and
// saturating hazard statistics for the stage controller.
module hazard_sequencer #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 8,
  parameter int CNT_WIDTH      = 16
) (
  input logic               clk,
  input logic               rstn,
  hazard_sequencer_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BRANCH_WAIT = 2'd1,
    REDIRECT    = 2'd2
  } state_t;

  localparam int                        WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]         WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0]         WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]         WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = REG_ADDR_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]      CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX   = {CNT_WIDTH{1'b1}};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                   input logic event_hit);
    if (event_hit && (value != CNT_MAX)) begin
      sat_inc = value + CNT_ONE;
    end else begin
      sat_inc = value;
    end
  endfunction

  state_t              state_r, state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic                load_use_s, data_hazard_s, branch_hazard_s, miss_s, timeout_s;
  logic                delayed_r, error_r;
  logic [CNT_WIDTH-1:0] data_cnt_r, branch_cnt_r, miss_cnt_r;

  // Load-use hit against the load currently in execute; x0 never creates a dependency.
  always_comb begin
    load_use_s = hz.decodeValid & hz.executeValid & hz.executeIsLoad &
                 (hz.executeRd != REG_ZERO) &
                 ((hz.decodeRs1Used & (hz.decodeRs1 == hz.executeRd)) |
                  (hz.decodeRs2Used & (hz.decodeRs2 == hz.executeRd)));
  end

  // Next-state and hazard outputs; priority is miss > data hazard > branch detect.
  always_comb begin
    state_nxt_s     = state_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    data_hazard_s   = load_use_s;
    branch_hazard_s = 1'b0;
    miss_s          = 1'b0;
    timeout_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (hz.decodeValid && hz.decodeIsBranch && !load_use_s) begin
          branch_hazard_s = 1'b1;
          wait_cnt_nxt_s  = WAIT_ZERO;
          state_nxt_s     = BRANCH_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BRANCH_WAIT: begin
        if (hz.branchResolved) begin
          if (hz.branchMispredict) begin
            miss_s        = 1'b1;
            data_hazard_s = 1'b0;
            state_nxt_s   = REDIRECT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          branch_hazard_s = 1'b1;
          wait_cnt_nxt_s  = wait_cnt_r + WAIT_ONE;
          if (wait_cnt_r == WAIT_LAST) begin
            timeout_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = BRANCH_WAIT;
          end
        end
      end
      REDIRECT: begin
        // Anything in decode now is on the flushed wrong path.
        data_hazard_s = 1'b0;
        state_nxt_s   = IDLE;
      end
      default: begin
        data_hazard_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase
  end

  // FSM state and branch wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      wait_cnt_r <= WAIT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Virtual-fetch delayed stall and sticky timeout flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      delayed_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      delayed_r <= branch_hazard_s & ~miss_s;
      error_r   <= error_r | timeout_s;
    end
  end

  // Saturating statistics; clear wins over a simultaneous event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_cnt_r   <= CNT_ZERO;
      branch_cnt_r <= CNT_ZERO;
      miss_cnt_r   <= CNT_ZERO;
    end else if (hz.statClear) begin
      data_cnt_r   <= CNT_ZERO;
      branch_cnt_r <= CNT_ZERO;
      miss_cnt_r   <= CNT_ZERO;
    end else begin
      data_cnt_r   <= sat_inc(data_cnt_r, data_hazard_s);
      branch_cnt_r <= sat_inc(branch_cnt_r, branch_hazard_s);
      miss_cnt_r   <= sat_inc(miss_cnt_r, miss_s);
    end
  end

  assign hz.isDataHazard          = data_hazard_s & rstn;
  assign hz.isBranchHazard        = branch_hazard_s & rstn;
  assign hz.isMiss                = miss_s & rstn;
  assign hz.isBranchHazardDelayed = delayed_r;
  assign hz.errorTimeout          = error_r;
  assign hz.dataHazardCycles      = data_cnt_r;
  assign hz.branchHazardCycles    = branch_cnt_r;
  assign hz.missCount             = miss_cnt_r;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench: a per-cycle vector table plus hand sequences for timeout,
// counter saturation/clear and reset in the middle of a branch wait.
module tb_hazard_sequencer;

  logic clk;
  logic rstn;
  int   pass_cnt;
  int   total_cnt;

  hazard_sequencer_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) hif ();

  hazard_sequencer #(.REG_ADDR_WIDTH(5), .TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv, db;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ev, el;
    logic [4:0] rd;
    logic       br, bm;
    logic       dh, bh, bhd, miss;
  } vec_t;

  vec_t tbl[21];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    hif.decodeValid      = v.dv;
    hif.decodeIsBranch   = v.db;
    hif.decodeRs1        = v.rs1;
    hif.decodeRs2        = v.rs2;
    hif.decodeRs1Used    = v.u1;
    hif.decodeRs2Used    = v.u2;
    hif.executeValid     = v.ev;
    hif.executeIsLoad    = v.el;
    hif.executeRd        = v.rd;
    hif.branchResolved   = v.br;
    hif.branchMispredict = v.bm;
  endtask

  task automatic idle_inputs();
    vec_t z;
    z = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    drive(z);
    hif.statClear = 1'b0;
  endtask

  task automatic load_use_on();
    hif.decodeValid   = 1'b1;
    hif.decodeIsBranch = 1'b0;
    hif.decodeRs1     = 5'd5;
    hif.decodeRs1Used = 1'b1;
    hif.executeValid  = 1'b1;
    hif.executeIsLoad = 1'b1;
    hif.executeRd     = 5'd5;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk_bit({tag, " dh"}, hif.isDataHazard, 1'b0);
    chk_bit({tag, " bh"}, hif.isBranchHazard, 1'b0);
    chk_bit({tag, " bhd"}, hif.isBranchHazardDelayed, 1'b0);
    chk_bit({tag, " miss"}, hif.isMiss, 1'b0);
    chk_bit({tag, " err"}, hif.errorTimeout, 1'b0);
    chk_cnt({tag, " dcnt"}, hif.dataHazardCycles, 4'd0);
    chk_cnt({tag, " bcnt"}, hif.branchHazardCycles, 4'd0);
    chk_cnt({tag, " mcnt"}, hif.missCount, 4'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    //          dv   db   rs1   rs2   u1   u2   ev   el   rd    br   bm    dh   bh   bhd  miss
    tbl[0]  = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,5'd3,5'd5,1'b1,1'b1,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,5'd3,5'd0,1'b1,1'b1,1'b1,1'b1,5'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,5'd3,5'd5,1'b1,1'b0,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,5'd5,5'd7,1'b1,1'b1,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,5'd5,5'd7,1'b1,1'b1,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,5'd5,5'd7,1'b1,1'b1,1'b1,1'b0,5'd5,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,5'd5,5'd7,1'b1,1'b1,1'b0,1'b1,5'd5,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,5'd5,5'd0,1'b1,1'b0,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,5'd5,5'd0,1'b1,1'b0,1'b0,1'b0,5'd5,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b1,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,5'd3,5'd5,1'b1,1'b1,1'b1,1'b1,5'd5,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1};
    tbl[15] = '{1'b1,1'b1,5'd3,5'd5,1'b1,1'b1,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b1,1'b1,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[18] = '{1'b1,1'b0,5'd3,5'd5,1'b1,1'b1,1'b1,1'b1,5'd5,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
    tbl[20] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};

    // Reset state
    rstn = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    all_zero("reset");
    rstn = 1'b1;

    // Per-cycle vector table
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk_bit($sformatf("row%0d dh", i), hif.isDataHazard, tbl[i].dh);
      chk_bit($sformatf("row%0d bh", i), hif.isBranchHazard, tbl[i].bh);
      chk_bit($sformatf("row%0d bhd", i), hif.isBranchHazardDelayed, tbl[i].bhd);
      chk_bit($sformatf("row%0d miss", i), hif.isMiss, tbl[i].miss);
      step();
    end
    @(negedge clk);
    chk_cnt("table dcnt", hif.dataHazardCycles, 4'd4);
    chk_cnt("table bcnt", hif.branchHazardCycles, 4'd5);
    chk_cnt("table mcnt", hif.missCount, 4'd1);
    chk_bit("table err", hif.errorTimeout, 1'b0);

    // Timeout: branch at cycle 0, never resolved
    idle_inputs();
    hif.statClear = 1'b1;
    step();
    hif.statClear = 1'b0;
    hif.decodeValid = 1'b1;
    hif.decodeIsBranch = 1'b1;
    @(negedge clk);
    chk_bit("to c0 bh", hif.isBranchHazard, 1'b1);
    step();
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk_bit($sformatf("to c%0d bh", c), hif.isBranchHazard, 1'b1);
      chk_bit($sformatf("to c%0d err", c), hif.errorTimeout, 1'b0);
      step();
    end
    @(negedge clk);
    chk_bit("to c9 bh", hif.isBranchHazard, 1'b0);
    chk_bit("to c9 err", hif.errorTimeout, 1'b1);
    step();
    hif.decodeValid = 1'b1;
    hif.decodeIsBranch = 1'b1;
    @(negedge clk);
    chk_bit("to nb bh", hif.isBranchHazard, 1'b1);
    step();
    idle_inputs();
    hif.branchResolved = 1'b1;
    @(negedge clk);
    chk_bit("to res bh", hif.isBranchHazard, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk_bit("to sticky err", hif.errorTimeout, 1'b1);
    chk_cnt("to bcnt", hif.branchHazardCycles, 4'd10);

    // Saturation and clear
    step();
    load_use_on();
    hif.statClear = 1'b1;
    step();
    hif.statClear = 1'b0;
    @(negedge clk);
    chk_cnt("sat cleared", hif.dataHazardCycles, 4'd0);
    for (int c = 0; c < 20; c++) step();
    @(negedge clk);
    chk_cnt("sat held", hif.dataHazardCycles, 4'd15);
    chk_bit("sat dh", hif.isDataHazard, 1'b1);
    step();
    hif.statClear = 1'b1;
    step();
    hif.statClear = 1'b0;
    @(negedge clk);
    chk_cnt("clr prio", hif.dataHazardCycles, 4'd0);
    step();
    @(negedge clk);
    chk_cnt("clr then inc", hif.dataHazardCycles, 4'd1);

    // Reset during BRANCH_WAIT
    step();
    idle_inputs();
    hif.decodeValid = 1'b1;
    hif.decodeIsBranch = 1'b1;
    step();
    idle_inputs();
    step();
    load_use_on();
    hif.branchResolved = 1'b0;
    @(negedge clk);
    chk_bit("mid bh", hif.isBranchHazard, 1'b1);
    #2;
    rstn = 1'b0;
    hif.branchResolved = 1'b1;
    hif.branchMispredict = 1'b1;
    #1;
    all_zero("mid rst");
    step();
    rstn = 1'b1;
    idle_inputs();
    hif.branchResolved = 1'b1;
    hif.branchMispredict = 1'b1;
    @(negedge clk);
    chk_bit("post bh", hif.isBranchHazard, 1'b0);
    chk_bit("post miss", hif.isMiss, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk_bit("post2 bh", hif.isBranchHazard, 1'b0);
    chk_bit("post2 bhd", hif.isBranchHazardDelayed, 1'b0);
    step();
    hif.decodeValid = 1'b1;
    hif.decodeIsBranch = 1'b1;
    @(negedge clk);
    chk_bit("new br bh", hif.isBranchHazard, 1'b1);
    step();
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
